cam_capture_v2: RTL and testbench

Parametrised successor capture block for OV7670-class byte-serial cameras. Samples the 8-bit pixel bus on pclk and assembles pixels in RGB565 (2 bytes/pixel) or Y-only grayscale (from YUV422). Emits frame-buffer write strobes with addr/dout, clipped to a configurable active window. Sits between the camera pins and the frame-buffer BRAM write port.

---
 rtl/cam_pkg.sv | 18 +
 rtl/cam_pix_assemble.sv | 56 +++++
 rtl/cam_capture_v2.sv | 213 +++++++++++++++++++++
 tb/tb_cam_capture_v2.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture block: capture FSM states,
// pixel mode encodings and the frame-size helper.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        SYNC      = 2'd1,
        ACTIVE    = 2'd2
    } cap_state_t;

    localparam logic MODE_RGB565 = 1'b0;
    localparam logic MODE_Y8     = 1'b1;

    function automatic int unsigned frame_size(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

endpackage

// File: rtl/cam_pix_assemble.sv
// Byte-to-pixel assembler: tracks the byte phase within a pixel, latches the
// RGB565 high byte and produces a combinational pixel-valid pulse with data.
module cam_pix_assemble
    import cam_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        byte_en,
    input  logic        clr,
    input  logic        mode,
    input  logic [7:0]  d,
    output logic        pix_valid,
    output logic [15:0] pix_data
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    // Phase/high-byte next state and pixel packing for the active mode.
    always_comb begin
        phase_d   = phase_q;
        hi_d      = hi_q;
        pix_valid = 1'b0;
        pix_data  = '0;
        if (clr) begin
            phase_d = 1'b0;
        end else if (byte_en) begin
            phase_d = ~phase_q;
            if (mode == MODE_Y8) begin
                if (!phase_q) begin
                    pix_valid = 1'b1;
                    pix_data  = {8'h00, d};
                end
            end else begin
                if (!phase_q) begin
                    hi_d = d;
                end else begin
                    pix_valid = 1'b1;
                    pix_data  = {hi_q, d};
                end
            end
        end
    end

    // Phase and high-byte registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: rtl/cam_capture_v2.sv
// Camera capture top: frame FSM, column/row counters with window clipping and
// registered frame-buffer write port. Optional macro CAP_GEOM_CHECK_EN adds
// the geom_err output flagging frames with unexpected geometry.
module cam_capture_v2
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned DOUT_W   = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DOUT_W-1:0] dout,
    output logic              we,
    output logic              frame_done,
`ifdef CAP_GEOM_CHECK_EN
    output logic              geom_err,
`endif
    output logic              busy
);

    localparam int unsigned CW = $clog2(H_ACTIVE + 1);
    localparam int unsigned RW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0]     H_LIM     = CW'(H_ACTIVE);
    localparam logic [RW-1:0]     V_LIM     = RW'(V_ACTIVE);
    localparam logic [RW-1:0]     V_LAST    = RW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(frame_size(H_ACTIVE, V_ACTIVE) - 1);

    cap_state_t        state_q, state_d;
    logic              mode_q, mode_d;
    logic              href_q, href_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              line_pix_q, line_pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DOUT_W-1:0] dout_q, dout_d;
    logic              we_q, we_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] wr_addr;
    logic              byte_en, clr, pix_valid;
    logic [15:0]       pix_data;

`ifdef CAP_GEOM_CHECK_EN
    localparam int unsigned PW = $clog2(H_ACTIVE + 2);
    localparam int unsigned LW = $clog2(V_ACTIVE + 2);
    localparam logic [PW-1:0] P_EXP = PW'(H_ACTIVE);
    localparam logic [PW-1:0] P_SAT = PW'(H_ACTIVE + 1);
    localparam logic [LW-1:0] L_EXP = LW'(V_ACTIVE);
    localparam logic [LW-1:0] L_SAT = LW'(V_ACTIVE + 1);
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic          bad_q, bad_d;
    logic          geom_err_q, geom_err_d;
`endif

    assign byte_en = (state_q == ACTIVE) && href && !vsync;
    assign clr     = vsync || !href || (state_q != ACTIVE);

    cam_pix_assemble u_pix (
        .pclk      (pclk),
        .rst       (rst),
        .byte_en   (byte_en),
        .clr       (clr),
        .mode      (mode_q),
        .d         (d),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    // FSM next state, counters, clipping and write-port next values.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        href_d       = 1'b0;
        col_d        = col_q;
        row_d        = row_q;
        base_d       = base_q;
        line_pix_d   = line_pix_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        we_d         = 1'b0;
        frame_done_d = 1'b0;
        wr_addr      = base_q + ADDR_W'(col_q);
`ifdef CAP_GEOM_CHECK_EN
        pcnt_d       = pcnt_q;
        lcnt_d       = lcnt_q;
        bad_d        = bad_q;
        geom_err_d   = geom_err_q;
`endif

        case (state_q)
            WAIT_SYNC: if (vsync) state_d = SYNC;
            SYNC: begin
                if (!vsync) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                end
            end
            ACTIVE: begin
                if (vsync) begin
                    state_d      = SYNC;
                    frame_done_d = 1'b1;
`ifdef CAP_GEOM_CHECK_EN
                    geom_err_d   = bad_q || (lcnt_q != L_EXP);
`endif
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        if (vsync) begin
            col_d      = '0;
            row_d      = '0;
            base_d     = '0;
            line_pix_d = 1'b0;
`ifdef CAP_GEOM_CHECK_EN
            pcnt_d     = '0;
            lcnt_d     = '0;
            bad_d      = 1'b0;
`endif
        end else if (state_q == ACTIVE) begin
            href_d = href;
            if (pix_valid) begin
                line_pix_d = 1'b1;
`ifdef CAP_GEOM_CHECK_EN
                if (pcnt_q != P_SAT) pcnt_d = pcnt_q + 1'b1;
`endif
                if (col_q < H_LIM && row_q < V_LIM && wr_addr <= ADDR_LAST) begin
                    we_d   = 1'b1;
                    addr_d = wr_addr;
                    dout_d = DOUT_W'(pix_data);
                    col_d  = col_q + 1'b1;
                end
            end
            // Line end: the row base only advances while a further stored row
            // exists, so it never points past the frame.
            if (href_q && !href) begin
                col_d      = '0;
                line_pix_d = 1'b0;
`ifdef CAP_GEOM_CHECK_EN
                pcnt_d     = '0;
`endif
                if (line_pix_q) begin
                    if (row_q < V_LIM)  row_d  = row_q + 1'b1;
                    if (row_q < V_LAST) base_d = base_q + H_STEP;
`ifdef CAP_GEOM_CHECK_EN
                    if (lcnt_q != L_SAT) lcnt_d = lcnt_q + 1'b1;
                    if (pcnt_q != P_EXP) bad_d  = 1'b1;
`endif
                end
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_SYNC;
            mode_q       <= MODE_RGB565;
            href_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            base_q       <= '0;
            line_pix_q   <= 1'b0;
            addr_q       <= '0;
            dout_q       <= '0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef CAP_GEOM_CHECK_EN
            pcnt_q       <= '0;
            lcnt_q       <= '0;
            bad_q        <= 1'b0;
            geom_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            href_q       <= href_d;
            col_q        <= col_d;
            row_q        <= row_d;
            base_q       <= base_d;
            line_pix_q   <= line_pix_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            we_q         <= we_d;
            frame_done_q <= frame_done_d;
`ifdef CAP_GEOM_CHECK_EN
            pcnt_q       <= pcnt_d;
            lcnt_q       <= lcnt_d;
            bad_q        <= bad_d;
            geom_err_q   <= geom_err_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ACTIVE);
`ifdef CAP_GEOM_CHECK_EN
    assign geom_err   = geom_err_q;
`endif

endmodule

// File: tb/tb_cam_capture_v2.sv
// Directed bench for cam_capture_v2 with a 4x3 window; geom_err checks are
// compiled in when CAP_GEOM_CHECK_EN is defined.
module tb_cam_capture_v2;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        mode;
    logic [16:0] addr;
    logic [15:0] dout;
    logic        we;
    logic        frame_done;
    logic        busy;
`ifdef CAP_GEOM_CHECK_EN
    logic        geom_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int fd_cnt   = 0;

    logic [16:0] log_a[$];
    logic [15:0] log_d[$];
    logic [16:0] exp_a[$];
    logic [15:0] exp_d[$];

    cam_capture_v2 #(
        .H_ACTIVE (4),
        .V_ACTIVE (3),
        .ADDR_W   (17),
        .DOUT_W   (16)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .mode       (mode),
        .addr       (addr),
        .dout       (dout),
        .we         (we),
        .frame_done (frame_done),
`ifdef CAP_GEOM_CHECK_EN
        .geom_err   (geom_err),
`endif
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    // Record every write and frame_done pulse shortly after the edge.
    always @(posedge pclk) begin
        #1;
        if (we === 1'b1) begin
            log_a.push_back(addr);
            log_d.push_back(dout);
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic put(input logic v, input logic h, input logic [7:0] b);
        @(negedge pclk);
        vsync = v;
        href  = h;
        d     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic start_frame();
        repeat (3) put(1'b1, 1'b0, 8'h00);
        idle(3);
    endtask

    task automatic end_frame();
        repeat (4) put(1'b1, 1'b0, 8'h00);
        @(negedge pclk);
    endtask

    task automatic line_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b1, first + 8'(i));
        idle(2);
    endtask

    task automatic line_y(input logic [7:0] first_y);
        for (int p = 0; p < 4; p++) begin
            put(1'b0, 1'b1, first_y + 8'(p));
            put(1'b0, 1'b1, 8'hAA);
        end
        idle(2);
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_d.delete();
        exp_a.delete();
        exp_d.delete();
        fd_cnt = 0;
    endtask

    task automatic expect_px(input int a, input logic [15:0] v);
        exp_a.push_back(17'(a));
        exp_d.push_back(v);
    endtask

    task automatic compare_logs(input string tag);
        int n;
        check({tag, "_nwrites"}, log_a.size(), exp_a.size());
        n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), log_a[i], exp_a[i]);
            check($sformatf("%s_dout%0d", tag, i), log_d[i], exp_d[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_aa;
        rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00; mode = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_addr", addr, 0);
        check("rst_dout", dout, 0);
        check("rst_we", we, 0);
        check("rst_fd", frame_done, 0);
        check("rst_busy", busy, 0);
`ifdef CAP_GEOM_CHECK_EN
        check("rst_geom", geom_err, 0);
`endif
        rst = 1'b0;
        idle(2);

        // RGB565, nominal 4x3 frame, bytes 0x00..0x17.
        clear_logs();
        mode = 1'b0;
        start_frame();
        check("rgb_busy", busy, 1);
        for (int l = 0; l < 3; l++) line_seq(8'(l * 8), 8);
        for (int k = 0; k < 12; k++) expect_px(k, {8'(2 * k), 8'(2 * k + 1)});
        end_frame();
        compare_logs("rgb");
        check("rgb_first", log_d.size() > 0 ? log_d[0] : 16'hDEAD, 16'h0001);
        check("rgb_last", log_d.size() > 0 ? log_d[log_d.size() - 1] : 16'hDEAD, 16'h1617);
        check("rgb_fd", fd_cnt, 1);
        check("rgb_busy_off", busy, 0);
`ifdef CAP_GEOM_CHECK_EN
        check("rgb_geom", geom_err, 0);
`endif

        // Y-only: Y bytes 0x10.., chroma 0xAA never stored.
        clear_logs();
        mode = 1'b1;
        start_frame();
        for (int l = 0; l < 3; l++) line_y(8'(8'h10 + l * 4));
        for (int k = 0; k < 12; k++) expect_px(k, 16'(8'h10 + k));
        end_frame();
        compare_logs("y8");
        n_aa = 0;
        foreach (log_d[i]) if (log_d[i] == 16'h00AA) n_aa++;
        check("y8_no_aa", n_aa, 0);
        check("y8_fd", fd_cnt, 1);
`ifdef CAP_GEOM_CHECK_EN
        check("y8_geom", geom_err, 0);
`endif

        // Oversized frame: 5 lines of 6 pixels clipped to 4x3.
        clear_logs();
        mode = 1'b0;
        start_frame();
        for (int l = 0; l < 5; l++) line_seq(8'(l * 12), 12);
        for (int l = 0; l < 3; l++)
            for (int p = 0; p < 4; p++)
                expect_px(l * 4 + p, {8'(l * 12 + 2 * p), 8'(l * 12 + 2 * p + 1)});
        end_frame();
        compare_logs("clip");
        check("clip_fd", fd_cnt, 1);
`ifdef CAP_GEOM_CHECK_EN
        check("clip_geom", geom_err, 1);
`endif

        // Odd-length first line drops its dangling byte.
        clear_logs();
        start_frame();
        line_seq(8'h30, 7);
        line_seq(8'h40, 8);
        line_seq(8'h50, 8);
        expect_px(0, 16'h3031); expect_px(1, 16'h3233); expect_px(2, 16'h3435);
        for (int p = 0; p < 4; p++) expect_px(4 + p, {8'(8'h40 + 2 * p), 8'(8'h41 + 2 * p)});
        for (int p = 0; p < 4; p++) expect_px(8 + p, {8'(8'h50 + 2 * p), 8'(8'h51 + 2 * p)});
        end_frame();
        compare_logs("odd");
`ifdef CAP_GEOM_CHECK_EN
        check("odd_geom", geom_err, 1);
`endif

        // Mid-line reset, then bytes without a vsync sequence are ignored.
        clear_logs();
        start_frame();
        put(1'b0, 1'b1, 8'h11);
        put(1'b0, 1'b1, 8'h22);
        @(posedge pclk);
        #1;
        check("mid_pre_we", we, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        clear_logs();
        line_seq(8'h60, 8);
        line_seq(8'h68, 8);
        check("nosync_writes", log_a.size(), 0);
        check("nosync_busy", busy, 0);
        start_frame();
        for (int l = 0; l < 3; l++) line_seq(8'(8'h70 + l * 8), 8);
        for (int k = 0; k < 12; k++) expect_px(k, {8'(8'h70 + 2 * k), 8'(8'h71 + 2 * k)});
        end_frame();
        compare_logs("resync");
        check("resync_fd", fd_cnt, 1);
`ifdef CAP_GEOM_CHECK_EN
        check("resync_geom", geom_err, 0);
`endif

        // Mode switched mid-frame only takes effect on the next frame.
        clear_logs();
        mode = 1'b0;
        start_frame();
        line_seq(8'h00, 8);
        mode = 1'b1;
        line_seq(8'h08, 8);
        line_seq(8'h10, 8);
        for (int k = 0; k < 12; k++) expect_px(k, {8'(2 * k), 8'(2 * k + 1)});
        end_frame();
        compare_logs("mchg_rgb");
        clear_logs();
        start_frame();
        for (int l = 0; l < 3; l++) line_y(8'(8'h40 + l * 4));
        for (int k = 0; k < 12; k++) expect_px(k, 16'(8'h40 + k));
        end_frame();
        compare_logs("mchg_y8");
        check("mchg_fd", fd_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
